// File: rtl/prbs8_checker.sv
// -----------------------------------------------------------------------------
// prbs8_checker
//   Receive-side checker for an 8-bit-per-word PRBS stream generated by the
//   polynomial x^8+x^6+x^5+x^4+1 (shift-left Fibonacci form). The checker
//   searches for LOCK_CNT consecutive self-consistent words, then runs a free
//   reference generator and counts mismatched words. LOSS_CNT consecutive
//   mismatches drop lock and restart the search.
//
//   Optional feature macro: PRBS8_CHK_STUCK_DETECT_EN
//     defined   -> a valid all-zero word sets the sticky 'stuck' flag and,
//                  when locked, forces a return to SEARCH (counted as one error)
//     undefined -> 'stuck' is tied 0; an all-zero word is an ordinary mismatch
// -----------------------------------------------------------------------------
module prbs8_checker #(
   parameter int unsigned LOCK_CNT = 4,  // consecutive matches to acquire lock (1..15)
   parameter int unsigned LOSS_CNT = 3   // consecutive mismatches to lose lock (1..15)
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        valid,
   input  logic [7:0]  data_in,
   input  logic        clear_cnt,
   output logic        locked,
   output logic        err_pulse,
   output logic [15:0] err_count,
   output logic        stuck
);

   localparam logic [3:0]  LOCK_CNT_C = 4'(LOCK_CNT);
   localparam logic [3:0]  LOSS_CNT_C = 4'(LOSS_CNT);
   localparam logic [15:0] CNT_MAX    = 16'hFFFF;

   typedef enum logic {
      ST_SEARCH = 1'b0,
      ST_LOCKED = 1'b1
   } state_t;

   // One PRBS step: shift left, feed back taps 8,6,5,4 into bit 0.
   function automatic logic [7:0] prbs_next(input logic [7:0] d);
      return {d[6:0], d[7] ^ d[5] ^ d[4] ^ d[3]};
   endfunction

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   state_t      state_q,     state_d;
   logic [7:0]  prev_q,      prev_d;       // last valid word seen (search seed)
   logic        prev_vld_q,  prev_vld_d;   // prev_q holds a real word since reset
   logic [3:0]  match_cnt_q, match_cnt_d;  // consecutive matches while searching
   logic [3:0]  miss_cnt_q,  miss_cnt_d;   // consecutive mismatches while locked
   logic [7:0]  expected_q,  expected_d;   // free-running reference while locked
   logic        err_pulse_q, err_pulse_d;
   logic [15:0] err_count_q, err_count_d;

   logic zero_word;   // current word is all zero
   logic stuck_hit;   // valid all-zero word that the stuck detector acts on
   logic err_hit;     // a counted error occurs this cycle

   assign zero_word = (data_in == 8'h00);

   // ---------------------------------------------------------------------------
   // Optional stuck-at-zero detector
   // ---------------------------------------------------------------------------
`ifdef PRBS8_CHK_STUCK_DETECT_EN
   logic stuck_q;

   assign stuck_hit = valid && zero_word;

   // Sticky flag: set on any valid all-zero word, cleared only by reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         stuck_q <= 1'b0;
      end else if (stuck_hit) begin
         stuck_q <= 1'b1;
      end
   end

   assign stuck = stuck_q;
`else
   assign stuck_hit = 1'b0;
   assign stuck     = 1'b0;
`endif

   // ---------------------------------------------------------------------------
   // Next-state logic: search/lock FSM, counters and error accounting
   // ---------------------------------------------------------------------------
   always_comb begin
      // NOTE: every variable gets a default before any branch so no path can
      // leave one unassigned; a missing default here would infer a latch.
      state_d     = state_q;
      prev_d      = prev_q;
      prev_vld_d  = prev_vld_q;
      match_cnt_d = match_cnt_q;
      miss_cnt_d  = miss_cnt_q;
      expected_d  = expected_q;
      err_pulse_d = 1'b0;
      err_hit     = 1'b0;

      if (valid) begin
         prev_d     = data_in;
         prev_vld_d = 1'b1;

         case (state_q)
            ST_SEARCH: begin
               // The all-zero word is a fixed point of the generator, so it
               // must never count toward lock.
               if (prev_vld_q && !zero_word && (data_in == prbs_next(prev_q))) begin
                  match_cnt_d = match_cnt_q + 4'd1;
                  if (match_cnt_d == LOCK_CNT_C) begin
                     state_d    = ST_LOCKED;
                     expected_d = prbs_next(data_in);
                     miss_cnt_d = 4'd0;
                  end
               end else begin
                  match_cnt_d = 4'd0;
               end
            end

            ST_LOCKED: begin
               // Reference keeps running regardless of the received word, so a
               // corrupted word cannot reseed it.
               expected_d = prbs_next(expected_q);
               if ((data_in != expected_q) || stuck_hit) begin
                  err_hit     = 1'b1;
                  err_pulse_d = 1'b1;
                  miss_cnt_d  = miss_cnt_q + 4'd1;
                  if ((miss_cnt_d == LOSS_CNT_C) || stuck_hit) begin
                     state_d     = ST_SEARCH;
                     match_cnt_d = 4'd0;
                     miss_cnt_d  = 4'd0;
                  end
               end else begin
                  miss_cnt_d = 4'd0;
               end
            end

            default: begin
               state_d = ST_SEARCH;
            end
         endcase
      end

      // Clear has priority over a simultaneous error; the pulse still fires.
      err_count_d = err_count_q;
      if (clear_cnt) begin
         err_count_d = 16'h0000;
      end else if (err_hit && (err_count_q != CNT_MAX)) begin
         err_count_d = err_count_q + 16'd1;
      end
   end

   // ---------------------------------------------------------------------------
   // State registers with synchronous reset (reset overrides valid/clear_cnt)
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values, independent of statement order.
      if (reset) begin
         state_q     <= ST_SEARCH;
         prev_q      <= 8'h00;
         prev_vld_q  <= 1'b0;
         match_cnt_q <= 4'd0;
         miss_cnt_q  <= 4'd0;
         expected_q  <= 8'h00;
         err_pulse_q <= 1'b0;
         err_count_q <= 16'h0000;
      end else begin
         state_q     <= state_d;
         prev_q      <= prev_d;
         prev_vld_q  <= prev_vld_d;
         match_cnt_q <= match_cnt_d;
         miss_cnt_q  <= miss_cnt_d;
         expected_q  <= expected_d;
         err_pulse_q <= err_pulse_d;
         err_count_q <= err_count_d;
      end
   end

   // Outputs come straight from registers.
   assign locked    = (state_q == ST_LOCKED);
   assign err_pulse = err_pulse_q;
   assign err_count = err_count_q;

endmodule

// File: tb/tb_prbs8_checker.sv
// -----------------------------------------------------------------------------
// tb_prbs8_checker
//   Directed bench for prbs8_checker. Stimulus tasks push the expected
//   post-edge outputs into a queue; a monitor pops one entry per clock, #1
//   after the rising edge, and compares. Two instances share the clock: 'dut'
//   with default parameters for functional vectors, and 'dut_sat' with
//   LOSS_CNT=15 so a long in-lock error burst can reach counter saturation.
//   Expectations follow PRBS8_CHK_STUCK_DETECT_EN when it is defined.
// -----------------------------------------------------------------------------
module tb_prbs8_checker;

   localparam int CLK_HALF = 5;

   logic clk;

   // default-parameter instance
   logic        reset, valid, clear_cnt;
   logic [7:0]  data_in;
   logic        locked, err_pulse, stuck;
   logic [15:0] err_count;

   // saturation instance
   logic        s_reset, s_valid, s_clear;
   logic [7:0]  s_data;
   logic        s_locked, s_err_pulse, s_stuck;
   logic [15:0] s_err_count;

   typedef struct {
      logic        sel;   // 0: dut, 1: dut_sat
      logic        lk;
      logic        pl;
      logic [15:0] cnt;
      logic        st;
      int          id;
   } exp_t;

   exp_t exp_q[$];

   int n_checks = 0;
   int n_errors = 0;
   int step_id  = 0;

   prbs8_checker dut (
      .clk       (clk),
      .reset     (reset),
      .valid     (valid),
      .data_in   (data_in),
      .clear_cnt (clear_cnt),
      .locked    (locked),
      .err_pulse (err_pulse),
      .err_count (err_count),
      .stuck     (stuck)
   );

   prbs8_checker #(.LOCK_CNT(4), .LOSS_CNT(15)) dut_sat (
      .clk       (clk),
      .reset     (s_reset),
      .valid     (s_valid),
      .data_in   (s_data),
      .clear_cnt (s_clear),
      .locked    (s_locked),
      .err_pulse (s_err_pulse),
      .err_count (s_err_count),
      .stuck     (s_stuck)
   );

   initial clk = 1'b0;
   always #CLK_HALF clk = ~clk;

   function automatic logic [7:0] nxt(input logic [7:0] d);
      return {d[6:0], d[7] ^ d[5] ^ d[4] ^ d[3]};
   endfunction

   task automatic check(input string name, input int id,
                        input logic [15:0] act, input logic [15:0] req);
      n_checks++;
      if (act !== req) begin
         n_errors++;
         $display("FAIL %s (step %0d): got %h, expected %h", name, id, act, req);
      end
   endtask

   // Monitor: compare one queued expectation per clock, just after the edge.
   always @(posedge clk) begin
      exp_t e;
      #1;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         if (e.sel == 1'b0) begin
            check("locked",    e.id, 16'(locked),    16'(e.lk));
            check("err_pulse", e.id, 16'(err_pulse), 16'(e.pl));
            check("err_count", e.id, err_count,      e.cnt);
            check("stuck",     e.id, 16'(stuck),     16'(e.st));
         end else begin
            check("sat_locked",    e.id, 16'(s_locked),    16'(e.lk));
            check("sat_err_pulse", e.id, 16'(s_err_pulse), 16'(e.pl));
            check("sat_err_count", e.id, s_err_count,      e.cnt);
            check("sat_stuck",     e.id, 16'(s_stuck),     16'(e.st));
         end
      end
   end

   // Drive one cycle on the selected instance (called at a falling edge) and
   // optionally queue the outputs expected after the next rising edge.
   task automatic drive(input logic sel, input logic r, input logic v,
                        input logic [7:0] d, input logic clr, input logic chk,
                        input logic el, input logic ep,
                        input logic [15:0] ec, input logic es);
      exp_t e;
      if (sel == 1'b0) begin
         reset = r; valid = v; data_in = d; clear_cnt = clr;
      end else begin
         s_reset = r; s_valid = v; s_data = d; s_clear = clr;
      end
      if (chk) begin
         e.sel = sel; e.lk = el; e.pl = ep; e.cnt = ec; e.st = es; e.id = step_id;
         exp_q.push_back(e);
      end
      step_id++;
      @(negedge clk);
   endtask

   task automatic ms(input logic v, input logic [7:0] d, input logic clr,
                     input logic el, input logic ep, input logic [15:0] ec,
                     input logic es);
      drive(1'b0, 1'b0, v, d, clr, 1'b1, el, ep, ec, es);
   endtask

   task automatic mrst(input logic [7:0] d, input logic clr);
      drive(1'b0, 1'b1, 1'b1, d, clr, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
   endtask

   // Watchdog: the run has a fixed length; anything beyond this is a hang.
   initial begin
      #(2 * CLK_HALF * 90000);
      $display("FAIL watchdog: simulation exceeded its cycle budget");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [7:0] exp_w;
      logic [7:0] bad_w;

      reset = 1'b1; valid = 1'b0; data_in = 8'h00; clear_cnt = 1'b0;
      s_reset = 1'b1; s_valid = 1'b0; s_data = 8'h00; s_clear = 1'b0;
      @(negedge clk);

      // ---------------- functional vectors on dut ----------------
      // Reset wins over valid and clear_cnt.
      mrst(8'h55, 1'b1);

      // Acquisition: first word seeds, four matches lock; expected becomes 23.
      ms(1, 8'h01, 0,  0, 0, 16'd0, 0);
      ms(1, 8'h02, 0,  0, 0, 16'd0, 0);
      ms(1, 8'h04, 0,  0, 0, 16'd0, 0);
      ms(1, 8'h08, 0,  0, 0, 16'd0, 0);
      ms(1, 8'h11, 0,  1, 0, 16'd0, 0);

      // Single error: 47 corrupted to 46, then the true successors 8E, 1C.
      ms(1, 8'h23, 0,  1, 0, 16'd0, 0);
      ms(1, 8'h46, 0,  1, 1, 16'd1, 0);
      ms(1, 8'h8E, 0,  1, 0, 16'd1, 0);
      ms(1, 8'h1C, 0,  1, 0, 16'd1, 0);

      // Valid gaps: idle cycles (junk data, including 00) change nothing.
      ms(0, 8'hFF, 0,  1, 0, 16'd1, 0);
      ms(1, 8'h38, 0,  1, 0, 16'd1, 0);
      ms(0, 8'h00, 0,  1, 0, 16'd1, 0);
      ms(1, 8'h71, 0,  1, 0, 16'd1, 0);
      ms(0, 8'hAA, 0,  1, 0, 16'd1, 0);
      ms(0, 8'hAA, 0,  1, 0, 16'd1, 0);
      ms(1, 8'hE2, 0,  1, 0, 16'd1, 0);

      // Clear coinciding with an error (C4 expected): count 0, pulse still 1.
      ms(1, 8'hC5, 1,  1, 1, 16'd0, 0);
      ms(1, 8'h89, 0,  1, 0, 16'd0, 0);

      // Loss of lock: three wrong words (12, 25, 4B expected).
      ms(1, 8'hFF, 0,  1, 1, 16'd1, 0);
      ms(1, 8'hFF, 0,  1, 1, 16'd2, 0);
      ms(1, 8'hFF, 0,  0, 1, 16'd3, 0);

      // Relock: first word reseeds (search mismatch is not counted), then 4 matches.
      ms(1, 8'h97, 0,  0, 0, 16'd3, 0);
      ms(1, 8'h2E, 0,  0, 0, 16'd3, 0);
      ms(1, 8'h5C, 0,  0, 0, 16'd3, 0);
      ms(1, 8'hB8, 0,  0, 0, 16'd3, 0);
      ms(1, 8'h70, 0,  1, 0, 16'd3, 0);

      // Clear alongside a correct word.
      ms(1, 8'hE0, 1,  1, 0, 16'd0, 0);

      // All-zero word while locked (C0 expected), then 81..19.
`ifdef PRBS8_CHK_STUCK_DETECT_EN
      ms(1, 8'h00, 0,  0, 1, 16'd1, 1);
      ms(1, 8'h81, 0,  0, 0, 16'd1, 1);
      ms(1, 8'h03, 0,  0, 0, 16'd1, 1);
      ms(1, 8'h06, 0,  0, 0, 16'd1, 1);
      ms(1, 8'h0C, 0,  0, 0, 16'd1, 1);
      ms(1, 8'h19, 0,  1, 0, 16'd1, 1);
`else
      ms(1, 8'h00, 0,  1, 1, 16'd1, 0);
      ms(1, 8'h81, 0,  1, 0, 16'd1, 0);
      ms(1, 8'h03, 0,  1, 0, 16'd1, 0);
      ms(1, 8'h06, 0,  1, 0, 16'd1, 0);
      ms(1, 8'h0C, 0,  1, 0, 16'd1, 0);
      ms(1, 8'h19, 0,  1, 0, 16'd1, 0);
`endif

      // Reset mid-lock: everything drops on that edge, full reacquisition needed.
      mrst(8'h32, 1'b0);
      ms(1, 8'h32, 0,  0, 0, 16'd0, 0);
      ms(1, 8'h64, 0,  0, 0, 16'd0, 0);
      ms(1, 8'hC9, 0,  0, 0, 16'd0, 0);
      ms(1, 8'h92, 0,  0, 0, 16'd0, 0);
      ms(1, 8'h24, 0,  1, 0, 16'd0, 0);
      ms(0, 8'h00, 0,  1, 0, 16'd0, 0);

      // ---------------- saturation on dut_sat ----------------
      drive(1, 1, 0, 8'h00, 0, 1,  0, 0, 16'd0, 0);
      drive(1, 0, 1, 8'h01, 0, 0,  0, 0, 16'd0, 0);
      drive(1, 0, 1, 8'h02, 0, 0,  0, 0, 16'd0, 0);
      drive(1, 0, 1, 8'h04, 0, 0,  0, 0, 16'd0, 0);
      drive(1, 0, 1, 8'h08, 0, 0,  0, 0, 16'd0, 0);
      drive(1, 0, 1, 8'h11, 0, 1,  1, 0, 16'd0, 0);

      // Groups of 14 wrong words plus 1 correct keep lock; 4681 groups = FFFE errors.
      exp_w = 8'h23;
      for (int g = 0; g < 4681; g++) begin
         for (int k = 0; k < 15; k++) begin
            bad_w = exp_w ^ 8'h01;
            if (bad_w == 8'h00) bad_w = exp_w ^ 8'h03;
            if (k < 14) begin
               drive(1, 0, 1, bad_w, 0, (g == 0 && k == 0),
                     1, 1, 16'd1, 0);
            end else begin
               drive(1, 0, 1, exp_w, 0, (g == 0 || g == 4680),
                     1, 0, (g == 0) ? 16'd14 : 16'hFFFE, 0);
            end
            exp_w = nxt(exp_w);
         end
      end

      // One more error saturates, the next must not wrap.
      bad_w = exp_w ^ 8'h01;
      if (bad_w == 8'h00) bad_w = exp_w ^ 8'h03;
      drive(1, 0, 1, bad_w, 0, 1,  1, 1, 16'hFFFF, 0);
      exp_w = nxt(exp_w);
      bad_w = exp_w ^ 8'h01;
      if (bad_w == 8'h00) bad_w = exp_w ^ 8'h03;
      drive(1, 0, 1, bad_w, 0, 1,  1, 1, 16'hFFFF, 0);
      exp_w = nxt(exp_w);
      drive(1, 0, 1, exp_w, 0, 1,  1, 0, 16'hFFFF, 0);
      drive(1, 0, 0, 8'h00, 0, 0,  1, 0, 16'hFFFF, 0);

      // Let the monitor drain the last expectation.
      @(negedge clk);
      @(negedge clk);
      check("queue_drained", -1, 16'(exp_q.size()), 16'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
